// File: rtl/noc_flit_receiver.sv
// Terminating receiver for a credit-based NoC link: buffers flits, streams them to an endpoint,
// returns one credit per drained flit and checks packet framing.
module noc_flit_receiver #(
   parameter int unsigned FLIT_WIDTH        = 128,
   parameter int unsigned DEST_WIDTH        = 6,
   parameter int unsigned FLIT_BUFFER_DEPTH = 4,
   parameter int unsigned CNT_WIDTH         = 16
) (
   input  logic                  clk_noc,
   input  logic                  rst_n,
   input  logic [FLIT_WIDTH-1:0] data_in,
   input  logic [DEST_WIDTH-1:0] dest_in,
   input  logic                  is_tail_in,
   input  logic                  send_in,
   output logic                  credit_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FLIT_WIDTH-1:0] out_data,
   output logic [DEST_WIDTH-1:0] out_dest,
   output logic                  out_last,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic                  overflow_err,
   output logic                  dest_err
);

   localparam int unsigned PtrW = $clog2(FLIT_BUFFER_DEPTH);
   localparam int unsigned OccW = PtrW + 1;
   localparam logic [OccW-1:0] OccFull = OccW'(FLIT_BUFFER_DEPTH);

   typedef enum logic [0:0] {
      StHead,
      StBody
   } state_e;

   // Flit storage
   logic [FLIT_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
   logic [DEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
   logic                  last_mem [FLIT_BUFFER_DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0] occ_q, occ_d;

   logic            credit_q;
   logic            overflow_q, overflow_d;

   state_e                state_q, state_d;
   logic [DEST_WIDTH-1:0] head_dest_q, head_dest_d;
   logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
   logic                  dest_err_q, dest_err_d;

   logic full;
   logic push;
   logic pop;

   assign out_valid = (occ_q != '0);
   assign full      = (occ_q == OccFull);
   assign pop       = out_valid && out_ready;
   // A full buffer still accepts a flit when the head is drained on the same edge.
   assign push      = send_in && (!full || pop);

   assign out_data = data_mem[rd_ptr_q];
   assign out_dest = dest_mem[rd_ptr_q];
   assign out_last = last_mem[rd_ptr_q];

   assign credit_out   = credit_q;
   assign overflow_err = overflow_q;
   assign dest_err     = dest_err_q;
   assign pkt_count    = pkt_count_q;

   always_ff @(posedge clk_noc) begin
      if (push) begin
         data_mem[wr_ptr_q] <= data_in;
         dest_mem[wr_ptr_q] <= dest_in;
         last_mem[wr_ptr_q] <= is_tail_in;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + OccW'(1);
         2'b01:   occ_d = occ_q - OccW'(1);
         default: occ_d = occ_q;
      endcase
      if (send_in && !push) begin
         overflow_d = 1'b1;
      end
   end

   // Framing tracker advances only on pops, so it sees flits in delivery order.
   always_comb begin
      state_d     = state_q;
      head_dest_d = head_dest_q;
      pkt_count_d = pkt_count_q;
      dest_err_d  = dest_err_q;
      if (pop) begin
         unique case (state_q)
            StHead: begin
               head_dest_d = out_dest;
               state_d     = out_last ? StHead : StBody;
            end
            StBody: begin
               if (out_dest != head_dest_q) begin
                  dest_err_d = 1'b1;
               end
               state_d = out_last ? StHead : StBody;
            end
            default: state_d = StHead;
         endcase
         if (out_last) begin
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         credit_q    <= 1'b0;
         overflow_q  <= 1'b0;
         state_q     <= StHead;
         head_dest_q <= '0;
         pkt_count_q <= '0;
         dest_err_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         credit_q    <= pop;
         overflow_q  <= overflow_d;
         state_q     <= state_d;
         head_dest_q <= head_dest_d;
         pkt_count_q <= pkt_count_d;
         dest_err_q  <= dest_err_d;
      end
   end

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Directed bench for noc_flit_receiver: fill/drain, overflow, streaming, dest mismatch and
// mid-packet reset, with hand-computed expectations.
module tb_noc_flit_receiver;

   logic         clk_noc = 1'b0;
   logic         rst_n;
   logic [127:0] data_in;
   logic [5:0]   dest_in;
   logic         is_tail_in;
   logic         send_in;
   logic         credit_out;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [5:0]   out_dest;
   logic         out_last;
   logic [15:0]  pkt_count;
   logic         overflow_err;
   logic         dest_err;

   int n_tests = 0;
   int n_fail  = 0;
   int credits;

   always #5 clk_noc = ~clk_noc;

   noc_flit_receiver dut (
      .clk_noc      (clk_noc),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .dest_in      (dest_in),
      .is_tail_in   (is_tail_in),
      .send_in      (send_in),
      .credit_out   (credit_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_dest     (out_dest),
      .out_last     (out_last),
      .pkt_count    (pkt_count),
      .overflow_err (overflow_err),
      .dest_err     (dest_err)
   );

   task automatic tick();
      @(posedge clk_noc);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic snd, input logic [127:0] d, input logic [5:0] ds,
                        input logic tl, input logic rdy);
      send_in    = snd;
      data_in    = d;
      dest_in    = ds;
      is_tail_in = tl;
      out_ready  = rdy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      do_reset();
      check("rst_valid", out_valid, 1'b0);
      check("rst_credit", credit_out, 1'b0);
      check("rst_pkt", pkt_count, 16'd0);
      check("rst_ovf", overflow_err, 1'b0);
      check("rst_derr", dest_err, 1'b0);

      // Fill with four flits while the consumer stalls.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 128'(i), 6'h05, (i == 4), 1'b0);
         tick();
         check("fill_valid", out_valid, 1'b1);
         check("fill_head", out_data, 128'h1);
         check("fill_credit", credit_out, 1'b0);
      end
      check("fill_ovf", overflow_err, 1'b0);

      // Full: fifth flit is dropped.
      drive(1'b1, 128'h5, 6'h05, 1'b0, 1'b0);
      tick();
      check("ovf_set", overflow_err, 1'b1);
      check("ovf_head_hold", out_data, 128'h1);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      check("ovf_sticky", overflow_err, 1'b1);

      // Full with same-cycle pop: push of single-flit packet 0x6 accepted.
      check("pp_head", out_data, 128'h1);
      drive(1'b1, 128'h6, 6'h05, 1'b1, 1'b1);
      tick();
      check("pp_credit", credit_out, 1'b1);
      check("pp_next", out_data, 128'h2);
      check("pp_ovf", overflow_err, 1'b1);
      check("pp_pkt", pkt_count, 16'd0);

      // Drain: 2,3,4(tail),6(head+tail).
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check("drain_d2", out_data, 128'h2);
      tick();
      check("drain_c2", credit_out, 1'b1);
      check("drain_d3", out_data, 128'h3);
      tick();
      check("drain_c3", credit_out, 1'b1);
      check("drain_d4", out_data, 128'h4);
      check("drain_l4", out_last, 1'b1);
      check("drain_pkt0", pkt_count, 16'd0);
      tick();
      check("drain_c4", credit_out, 1'b1);
      check("drain_pkt1", pkt_count, 16'd1);
      check("drain_d6", out_data, 128'h6);
      tick();
      check("drain_c6", credit_out, 1'b1);
      check("drain_pkt2", pkt_count, 16'd2);
      check("drain_empty", out_valid, 1'b0);
      tick();
      check("drain_credit_end", credit_out, 1'b0);
      check("drain_derr", dest_err, 1'b0);

      // Streaming: 64 flits, 16 packets, push and pop every cycle.
      do_reset();
      credits = 0;
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 128'(32'h100 + i), 6'h0A, (i % 4 == 3), 1'b1);
         if (i == 0) begin
            check("strm_no_bypass", out_valid, 1'b0);
         end else begin
            check("strm_valid", out_valid, 1'b1);
            check("strm_data", out_data, 128'(32'h100 + i - 1));
         end
         tick();
         if (credit_out) credits++;
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check("strm_last", out_data, 128'(32'h100 + 63));
      tick();
      if (credit_out) credits++;
      check("strm_drained", out_valid, 1'b0);
      tick();
      if (credit_out) credits++;
      check("strm_credits", credits, 64);
      check("strm_pkt", pkt_count, 16'd16);
      check("strm_ovf", overflow_err, 1'b0);
      check("strm_derr", dest_err, 1'b0);

      // Dest mismatch inside a packet.
      do_reset();
      drive(1'b1, 128'hA, 6'h05, 1'b0, 1'b0);
      tick();
      drive(1'b1, 128'hB, 6'h09, 1'b0, 1'b0);
      tick();
      drive(1'b1, 128'hC, 6'h09, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check("derr_dA", out_data, 128'hA);
      tick();
      check("derr_head_ok", dest_err, 1'b0);
      check("derr_dB", out_data, 128'hB);
      check("derr_destB", out_dest, 6'h09);
      tick();
      check("derr_set", dest_err, 1'b1);
      check("derr_dC", out_data, 128'hC);
      check("derr_pkt0", pkt_count, 16'd0);
      tick();
      check("derr_pkt1", pkt_count, 16'd1);
      check("derr_sticky", dest_err, 1'b1);

      // Reset with two body-less flits buffered mid-packet.
      drive(1'b1, 128'h21, 6'h03, 1'b0, 1'b0);
      tick();
      drive(1'b1, 128'h22, 6'h03, 1'b0, 1'b1);
      tick();
      // One flit popped (head dest 3), one buffered: framing is in BODY.
      do_reset();
      check("mrst_valid", out_valid, 1'b0);
      check("mrst_pkt", pkt_count, 16'd0);
      check("mrst_derr", dest_err, 1'b0);
      check("mrst_ovf", overflow_err, 1'b0);
      check("mrst_credit", credit_out, 1'b0);
      drive(1'b1, 128'h31, 6'h11, 1'b0, 1'b0);
      tick();
      drive(1'b1, 128'h32, 6'h11, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check("mrst_head", out_data, 128'h31);
      tick();
      check("mrst_tail", out_data, 128'h32);
      tick();
      check("mrst_new_derr", dest_err, 1'b0);
      check("mrst_new_pkt", pkt_count, 16'd1);
      check("mrst_empty", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_flit_receiver.md
Name: noc_flit_receiver

Overview:
- Terminating receiver for one router output port on the credit-based NoC link (data/dest/is_tail/send forward, credit backward).
- Buffers incoming flits in a FLIT_BUFFER_DEPTH FIFO and presents them on a valid/ready stream to an endpoint consumer.
- Returns one credit per drained flit.
- Tracks packet framing and counts delivered packets, with sticky error flags for link overflow and intra-packet dest mismatch.

Parameters:
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 6, dest field width ({tid, tdest}).
- FLIT_BUFFER_DEPTH, 4, FIFO entries; must equal the transmitter's initial credit count; power of two, >=2.
- CNT_WIDTH, 16, packet counter width.

Ports:
- clk_noc  in  1  NoC clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  FLIT_WIDTH  flit payload from router output.
- dest_in  in  DEST_WIDTH  flit destination.
- is_tail_in  in  1  flit is last of packet.
- send_in  in  1  flit valid this cycle; no backpressure on this side.
- credit_out  out  1  one-cycle pulse returning one buffer credit.
- out_valid  out  1  head flit available.
- out_ready  in  1  consumer accepts head flit.
- out_data  out  FLIT_WIDTH  head flit payload.
- out_dest  out  DEST_WIDTH  head flit dest.
- out_last  out  1  head flit is_tail.
- pkt_count  out  CNT_WIDTH  packets delivered (tail flits popped), wraps.
- overflow_err  out  1  sticky: flit arrived with no free entry.
- dest_err  out  1  sticky: body/tail flit dest differs from its head flit dest.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FIFO empty; out_valid=0, credit_out=0, pkt_count=0, overflow_err=0, dest_err=0; FSM to HEAD.
  - No credits are emitted on reset exit; the transmitter starts with FLIT_BUFFER_DEPTH credits.
  - Reset mid-packet discards all buffered flits and in-flight framing state.
- Push:
  - send_in=1 at edge k writes {data_in, dest_in, is_tail_in} into the tail slot.
  - The flit is visible on out_* with out_valid=1 from cycle k+1. Write-to-output latency is 1 cycle.
- Pop:
  - A pop occurs when out_valid && out_ready at an edge.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - out_data/out_dest/out_last are don't-care when out_valid=0.
- Credit:
  - credit_out=1 for exactly the cycle after each pop, i.e. a registered pulse per pop.
  - Back-to-back pops give back-to-back credit pulses.
- Count and occupancy:
  - occupancy = pushes − pops, range 0..FLIT_BUFFER_DEPTH.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from an occupancy counter of log2(DEPTH)+1 bits.
- Simultaneous push and pop:
  - Both take effect; occupancy is unchanged.
  - When empty, a same-cycle push is not poppable; there is no combinational bypass.
  - When full, a push with a same-cycle pop is accepted (slot freed this edge).
- Overflow:
  - send_in=1 with occupancy==DEPTH and no same-cycle pop: flit dropped, FIFO unchanged, overflow_err set.
  - overflow_err stays set until reset.
- Framing FSM (output side, advances on pop):
  - HEAD: on pop, latch head_dest=out_dest. If out_last=1, stay in HEAD and increment pkt_count. Otherwise go to BODY.
  - BODY: on pop, if out_dest != head_dest, set dest_err (sticky). If out_last=1, go to HEAD and increment pkt_count; otherwise stay in BODY.
  - Single-flit packets (head is also tail) are legal.
- pkt_count:
  - Updates on the edge of the tail pop; visible the next cycle.
  - Wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- Errors never stall the datapath.

Test Plan:
- Reset, then send 4 flits (data 0x1..0x4, dest 6'h05, tail on the 4th) with out_ready=0 -> out_valid=1 from the cycle after the first send with out_data=0x1; no credit_out pulses; occupancy full; no overflow_err.
- Same state, out_ready=1 for 4 cycles -> out_data sequence 0x1,0x2,0x3,0x4; credit_out high for 4 consecutive cycles, each lagging its pop by 1; pkt_count 0->1 after the 4th pop.
- Full FIFO, send 5th flit with out_ready=0 -> flit dropped, overflow_err=1 and remains 1; repeat the sequence with a pop in the same cycle -> flit accepted and overflow_err unchanged.
- Streaming: send_in=1 and out_ready=1 every cycle for 64 flits in 16 four-flit packets -> steady state 1 flit/cycle throughput, occupancy never exceeds 1, 64 credit pulses, pkt_count=16, no errors.
- Packet head dest 6'h05 followed by a body flit with dest 6'h09 -> dest_err=1 on that pop; data still delivered; pkt_count increments at tail.
- rst_n=0 for one cycle while 2 flits are buffered mid-packet -> next cycle out_valid=0, pkt_count=0, both error flags 0; the next flit is treated as a head.
